// File: rtl/adc_moving_avg_pkg.sv
// Shared constants and state type for the ADC boxcar averaging filter.
// Sample limits describe the offset-removed front-end output range.
package adc_moving_avg_pkg;

    localparam int ADC_DATA_W     = 11;
    localparam int ADC_LOG2_DEPTH = 3;
    localparam int ADC_SAMPLE_MIN = -1024;
    localparam int ADC_SAMPLE_MAX = 1023;

    typedef enum logic [0:0] {
        MA_FILL = 1'b0,
        MA_RUN  = 1'b1
    } ma_state_e;

endpackage

// File: rtl/adc_moving_avg_ma_delay_line.sv
// Circular delay line of the last DEPTH samples; exposes the word about to be overwritten.
// Entries read as zero until written, so the running sum is exact while the window fills.
module ma_delay_line #(
    parameter int DATA_W     = 11,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic signed [DATA_W-1:0] line_reg [DEPTH];
    logic [LOG2_DEPTH-1:0]    wr_ptr_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    line_reg[gi] <= '0;
                end else if (clr) begin
                    line_reg[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == LOG2_DEPTH'(gi))) begin
                    line_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + LOG2_DEPTH'(1);
        end
    end

    assign oldest = line_reg[wr_ptr_reg];

endmodule

// File: rtl/adc_moving_avg.sv
// Boxcar moving-average filter: mean of the last 2**LOG2_DEPTH signed ADC samples.
// Running sum updated one edge after a strobe, registered mean one edge later.
module adc_moving_avg
    import adc_moving_avg_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_DEPTH = ADC_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_stb,
    input  logic                     flush,
    output logic signed [DATA_W-1:0] avg_out,
    output logic                     avg_valid,
    output logic                     win_full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;

    ma_state_e                state_reg;
    logic [LOG2_DEPTH-1:0]    fill_cnt_reg;
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [DATA_W-1:0] oldest_word;
    logic                     pending_reg;
    logic                     fill_last;
    logic                     line_wr;

    // A strobe coinciding with flush is dropped entirely.
    assign line_wr = sample_stb && !flush;

    ma_delay_line #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (line_wr),
        .wr_data (sample_in),
        .oldest  (oldest_word)
    );

    // SUM_W bits hold DEPTH full-scale samples, so the sum cannot wrap.
    assign sum_next  = sum_reg + SUM_W'(sample_in) - SUM_W'(oldest_word);
    assign fill_last = (state_reg == MA_FILL) && (fill_cnt_reg == LOG2_DEPTH'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= MA_FILL;
            fill_cnt_reg <= '0;
            sum_reg      <= '0;
            pending_reg  <= 1'b0;
            win_full     <= 1'b0;
            avg_valid    <= 1'b0;
            avg_out      <= '0;
        end else if (flush) begin
            // avg_out deliberately keeps the last published mean.
            state_reg    <= MA_FILL;
            fill_cnt_reg <= '0;
            sum_reg      <= '0;
            pending_reg  <= 1'b0;
            win_full     <= 1'b0;
            avg_valid    <= 1'b0;
        end else begin
            avg_valid   <= pending_reg;
            pending_reg <= 1'b0;
            if (pending_reg) begin
                avg_out <= DATA_W'(sum_reg >>> LOG2_DEPTH);
            end
            if (sample_stb) begin
                sum_reg <= sum_next;
                if (state_reg == MA_FILL) begin
                    fill_cnt_reg <= fill_cnt_reg + LOG2_DEPTH'(1);
                    if (fill_last) begin
                        state_reg   <= MA_RUN;
                        win_full    <= 1'b1;
                        pending_reg <= 1'b1;
                    end
                end else begin
                    pending_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg with hand-computed expected means.
module tb_adc_moving_avg;
    import adc_moving_avg_pkg::*;

    logic                         clk;
    logic                         rst;
    logic signed [ADC_DATA_W-1:0] sample_in;
    logic                         sample_stb;
    logic                         flush;
    logic signed [ADC_DATA_W-1:0] avg_out;
    logic                         avg_valid;
    logic                         win_full;

    int check_cnt;
    int error_cnt;
    int got_q[$];

    adc_moving_avg dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .sample_stb (sample_stb),
        .flush      (flush),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .win_full   (win_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every published mean is captured mid-cycle.
    always @(negedge clk) begin
        if (avg_valid === 1'b1) got_q.push_back(int'(avg_out));
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        sample_in  = ADC_DATA_W'(v);
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        check_cnt  = 0;
        error_cnt  = 0;
        rst        = 1'b0;
        sample_in  = '0;
        sample_stb = 1'b0;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avg_out", avg_out, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_win_full", win_full, 0);
        rst = 1'b1;
        idle(1);

        // 1: fill with +100, pulse exactly two edges after the 8th strobe
        for (int i = 0; i < 7; i++) send(100);
        idle(3);
        check("t1_no_valid_fill", got_q.size(), 0);
        check("t1_not_full", win_full, 0);
        send(100);
        check("t1_win_full", win_full, 1);
        check("t1_valid_not_yet", avg_valid, 0);
        idle(1);
        check("t1_valid_pulse", avg_valid, 1);
        check("t1_avg_out", avg_out, 100);
        idle(1);
        check("t1_pulse_ends", avg_valid, 0);
        got_q.delete();

        // 2: four strobes of -100 -> 75, 50, 25, 0
        for (int i = 0; i < 4; i++) send(-100);
        idle(3);
        check("t2_count", got_q.size(), 4);
        check("t2_avg0", got_q[0], 75);
        check("t2_avg1", got_q[1], 50);
        check("t2_avg2", got_q[2], 25);
        check("t2_avg3", got_q[3], 0);
        got_q.delete();

        // 3: floor toward -inf
        for (int i = 0; i < 7; i++) send(0);
        send(-1);
        idle(3);
        check("t3_count", got_q.size(), 8);
        check("t3_first_floor", got_q[0], -13);
        check("t3_third_floor", got_q[2], -38);
        check("t3_last", got_q[7], -1);
        got_q.delete();
        for (int i = 0; i < 8; i++) send(-1);
        idle(3);
        check("t3_all_m1", got_q[7], -1);
        got_q.delete();

        // 4: full-scale extremes
        for (int i = 0; i < 8; i++) send(ADC_SAMPLE_MIN);
        idle(3);
        check("t4_min_first", got_q[0], -129);
        check("t4_min_last", got_q[7], -1024);
        got_q.delete();
        for (int i = 0; i < 8; i++) send(ADC_SAMPLE_MAX);
        idle(3);
        check("t4_max_first", got_q[0], -769);
        check("t4_max_last", got_q[7], 1023);
        got_q.delete();

        // 5: back-to-back ramp after a flush
        pulse_flush();
        check("t5_flush_not_full", win_full, 0);
        for (int i = 0; i < 16; i++) send(i);
        idle(3);
        check("t5_count", got_q.size(), 9);
        for (int k = 0; k < 9; k++) check($sformatf("t5_ramp%0d", k), got_q[k], 3 + k);
        got_q.delete();

        // 6: flush coincident with strobe in RUN drops the sample
        sample_in  = ADC_DATA_W'(500);
        sample_stb = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        flush      = 1'b0;
        idle(3);
        check("t6_no_valid", got_q.size(), 0);
        check("t6_not_full", win_full, 0);
        check("t6_avg_hold", avg_out, 11);
        for (int i = 0; i < 7; i++) send(8);
        idle(3);
        check("t6_seven_no_valid", got_q.size(), 0);
        send(8);
        idle(3);
        check("t6_eighth_valid", got_q.size(), 1);
        check("t6_eighth_avg", got_q[0], 8);
        got_q.delete();

        // 6b: asynchronous reset mid-FILL
        pulse_flush();
        for (int i = 0; i < 3; i++) send(50);
        #2;
        rst = 1'b0;
        #1;
        check("t6_arst_avg_out", avg_out, 0);
        check("t6_arst_valid", avg_valid, 0);
        check("t6_arst_full", win_full, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        for (int i = 0; i < 7; i++) send(16);
        idle(3);
        check("t6_refill_no_valid", got_q.size(), 0);
        send(16);
        idle(3);
        check("t6_refill_count", got_q.size(), 1);
        check("t6_refill_avg", got_q[0], 16);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
